branch_predictor: RTL
=====================

# branch_predictor

IF-stage dynamic branch predictor for the 5-stage pipelined CPU. It keeps a table of 2-bit saturating counters, indexed by PC, optionally XORed with a global history register (gshare). The fetch stage looks it up combinationally each cycle; the branch-resolving stage (ID/EX) updates it. It also raises a flush request on misprediction and maintains branch/mispredict statistics, so the bench can report them next to the stall and flush counts.

## Interface
- ENTRIES, 16, number of 2-bit counters; power of two, 4..256
- IDX_W, 4, log2(ENTRIES)
- USE_GSHARE, 0, 0: index = pc[IDX_W+1:2]; 1: index = pc[IDX_W+1:2] ^ ghr
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  enable; 0 blocks table/GHR/statistics updates and forces predict_taken_o=0
- pc_i  in  32  IF-stage PC to look up
- predict_taken_o  out  1  prediction for pc_i (combinational)
- ghr_o  out  IDX_W  current GHR; the pipeline carries it with the instruction
- update_valid_i  in  1  resolved conditional branch present this cycle
- update_pc_i  in  32  PC of the resolved branch
- update_ghr_i  in  IDX_W  GHR value captured when that branch was fetched
- update_pred_i  in  1  prediction made for that branch (carried down the pipeline)
- update_taken_i  in  1  actual outcome
- flush_o  out  1  mispredict: update_valid_i & start_i & (update_pred_i != update_taken_i) (combinational)
- branch_cnt_o  out  16  resolved branches, saturating
- miss_cnt_o  out  16  mispredicts, saturating

## Operation
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Prediction = bit[1] of the indexed entry.
- Lookup index: pc_i[IDX_W+1:2], XOR ghr_o when USE_GSHARE=1. pc_i[1:0] is ignored.
- Update index: update_pc_i[IDX_W+1:2], XOR update_ghr_i when USE_GSHARE=1. The GHR shown at lookup time is never used for updates.
- Update conditions: all updates require update_valid_i=1 and start_i=1.
- Update on taken: entry = min(entry+1, 11).
- Update on not-taken: entry = max(entry-1, 00). No wrap-around at either end.
- GHR: on each update, ghr <= {ghr[IDX_W-2:0], update_taken_i}. The GHR is present but ignored by indexing when USE_GSHARE=0.
- Statistics: branch_cnt_o increments on each update. miss_cnt_o increments when flush_o=1. Both hold at 16'hFFFF.
- Flush: flush_o is only a request. Squashing IF/ID and redirecting the PC are the flush unit's job.

## Timing
- Reset (rst_i=1 at an edge): every entry <= 01 (WNT), ghr <= 0, branch_cnt_o <= 0, miss_cnt_o <= 0.
- While rst_i=1: predict_taken_o=0 and flush_o=0. Reset overrides a concurrent update.
- Reset mid-run: all state reinitialises at the next edge, regardless of in-flight updates.
- Lookup latency: 0 cycles (combinational read).
- Update latency: the new value is visible to lookup in the cycle after the update edge.
- Same-index collision: a lookup and an update to the same index in one cycle returns the pre-update value (no bypass). The same applies to ghr_o.
- One update per cycle maximum. Holding update_valid_i high for N cycles yields N updates.
- start_i=0: all state holds; predict_taken_o=0, flush_o=0.
- Outputs only change at clock edges, except the combinational outputs predict_taken_o, flush_o and ghr_o-derived lookup.

## Test plan
- Reset default: assert rst_i 1 cycle, start_i=1, pc_i=0x0 -> predict_taken_o=0, ghr_o=0, branch_cnt_o=0, miss_cnt_o=0.
- Saturation, USE_GSHARE=0:
  - 4 taken updates at update_pc_i=0x8 -> entry[2] follows 01->10->11->11; predict_taken_o=1 for pc_i=0x8 from the cycle after the first update.
  - Then 4 not-taken updates -> entry reaches 00 and stays; predict_taken_o=0 for pc_i=0x8 from the cycle after the second not-taken.
- Aliasing: update taken twice at 0x8, look up pc_i=0x48 (ENTRIES=16) -> predict_taken_o=1. Look up pc_i=0xC -> 0.
- Mispredict stats: 3 updates with (pred,taken) = (0,1), (1,1), (1,0) -> flush_o pulses in the 1st and 3rd cycles only; branch_cnt_o=3, miss_cnt_o=2.
- Gshare, USE_GSHARE=1:
  - Updates taken, taken, not-taken -> ghr_o=4'b0110.
  - Taken update at update_pc_i=0x4 with update_ghr_i=4'b0110 -> entry[1^6=7] becomes 10.
  - Then pc_i=0x4 with ghr_o=0110 predicts 1; pc_i=0x1C with ghr_o=0 predicts 1.
- Start gating and reset mid-operation:
  - start_i=0 with update_valid_i=1 for 5 cycles -> counters and table unchanged, flush_o=0.
  - rst_i=1 in the same cycle as an update -> all entries 01, counts 0 after the edge.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter branch predictor with optional gshare indexing and mispredict statistics
module branch_predictor #(
    parameter int ENTRIES    = 16,
    parameter int IDX_W      = 4,
    parameter bit USE_GSHARE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      pc_i,
    output logic             predict_taken_o,
    output logic [IDX_W-1:0] ghr_o,
    input  logic             update_valid_i,
    input  logic [31:0]      update_pc_i,
    input  logic [IDX_W-1:0] update_ghr_i,
    input  logic             update_pred_i,
    input  logic             update_taken_i,
    output logic             flush_o,
    output logic [15:0]      branch_cnt_o,
    output logic [15:0]      miss_cnt_o
);
    logic [1:0]       table_q [ENTRIES];
    logic [1:0]       table_d [ENTRIES];
    logic [IDX_W-1:0] ghr_q, ghr_d;
    logic [15:0]      branch_cnt_q, branch_cnt_d;
    logic [15:0]      miss_cnt_q, miss_cnt_d;
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [1:0]       up_entry;
    logic             upd;

    // The lookup uses the live GHR; the update uses the GHR captured at fetch time.
    assign lk_idx          = pc_i[IDX_W+1:2] ^ (USE_GSHARE ? ghr_q : '0);
    assign up_idx          = update_pc_i[IDX_W+1:2] ^ (USE_GSHARE ? update_ghr_i : '0);
    assign up_entry        = table_q[up_idx];
    assign upd             = update_valid_i & start_i & ~rst_i;
    assign predict_taken_o = start_i & ~rst_i & table_q[lk_idx][1];
    assign flush_o         = upd & (update_pred_i != update_taken_i);
    assign ghr_o           = ghr_q;
    assign branch_cnt_o    = branch_cnt_q;
    assign miss_cnt_o      = miss_cnt_q;

    // Next state: saturating counter step at the update index, GHR shift, saturating statistics.
    always_comb begin
        table_d = table_q;
        table_d[up_idx] = !upd ? up_entry :
                          update_taken_i ? ((up_entry == 2'b11) ? 2'b11 : up_entry + 2'd1) :
                          ((up_entry == 2'b00) ? 2'b00 : up_entry - 2'd1);
        ghr_d        = upd ? {ghr_q[IDX_W-2:0], update_taken_i} : ghr_q;
        branch_cnt_d = (upd && branch_cnt_q != 16'hFFFF) ? branch_cnt_q + 16'd1 : branch_cnt_q;
        miss_cnt_d   = (flush_o && miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;
    end

    // State registers; reset puts every counter at weakly-not-taken and clears history and stats.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
            ghr_q        <= '0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            table_q      <= table_d;
            ghr_q        <= ghr_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end
endmodule
